// File: rtl/mem_access_stage.sv
// mem_access_stage -- MEM pipeline stage.
//
// Purpose: takes the EX/MEM register outputs, runs loads and stores over a
// req/ack data-memory bus and drives the MEM/WB register inputs. Stores get
// byte enables and lane-replicated write data. Loads are aligned and then
// sign- or zero-extended. stall_o holds the upstream pipeline while a bus
// transaction is outstanding.
//
// All state changes on the FALLING edge of clk_i. Reset is asynchronous and
// active-low (rst_n_i).
//
// Bus handshake: dmem_req_o rises on the edge that enters BUSY. While it is
// high, dmem_we_o, dmem_addr_o, dmem_be_o and dmem_wdata_o do not change.
// A transfer completes at the first falling edge in BUSY at which dmem_ack_i
// is high, and dmem_rdata_i is valid in that same cycle. dmem_req_o drops at
// that edge. An ack seen outside BUSY is ignored.
//
// Ports:
//   clk_i, rst_n_i               clock (falling edge), async active-low reset
//   mem_ctrl_i[4:0]              [0] read, [1] write, [3:2] size, [4] unsigned
//   wb_ctrl_i / wb_ctrl_o        WB control; bit 0 (reg_write) is masked
//                                while the access is in flight
//   result_i / alu_result_o      ALU result (byte address); passed through
//   src2_i                       store data
//   rd_i / rd_o                  destination register; passed through
//   stall_o                      hold upstream stages
//   dmem_*                       data-memory bus
//   mem_data_o                   extended load data (load_q)
//   state_dbg_o                  FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Optional build macro MISALIGN_EXC_EN adds the ports misalign_o and
// bad_addr_o. When it is set, a misaligned half or word access skips the
// bus and goes straight to DONE, where it flags an exception. When it is not
// set, the low address bits of half and word accesses are ignored.
module mem_access_stage #(
  parameter int DW  = 32,
  parameter int RW  = 5,
  parameter int WBW = 2
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic [4:0]     mem_ctrl_i,
  input  logic [WBW-1:0] wb_ctrl_i,
  input  logic [DW-1:0]  result_i,
  input  logic [DW-1:0]  src2_i,
  input  logic [RW-1:0]  rd_i,
  output logic           stall_o,
  output logic           dmem_req_o,
  output logic           dmem_we_o,
  output logic [DW-1:0]  dmem_addr_o,
  output logic [3:0]     dmem_be_o,
  output logic [DW-1:0]  dmem_wdata_o,
  input  logic           dmem_ack_i,
  input  logic [DW-1:0]  dmem_rdata_i,
  output logic [WBW-1:0] wb_ctrl_o,
  output logic [DW-1:0]  alu_result_o,
  output logic [DW-1:0]  mem_data_o,
  output logic [RW-1:0]  rd_o,
`ifdef MISALIGN_EXC_EN
  output logic           misalign_o,
  output logic [DW-1:0]  bad_addr_o,
`endif
  output logic [1:0]     state_dbg_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] load_q, load_d;

  logic          mem_read, mem_write, access, uns;
  logic [1:0]    size, a;
  logic [3:0]    be_fmt;
  logic [DW-1:0] wdata_fmt, load_ext;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic          misal;

  assign mem_read  = mem_ctrl_i[0];
  assign mem_write = mem_ctrl_i[1];
  assign size      = mem_ctrl_i[3:2];
  assign uns       = mem_ctrl_i[4];
  assign access    = mem_read | mem_write;
  assign a         = result_i[1:0];

  // Store formatting: enables follow the address, data is replicated into
  // every lane so the enables alone select the target bytes.
  always_comb begin
    be_fmt    = 4'b1111;
    wdata_fmt = src2_i;
    case (size)
      2'b00: begin
        be_fmt    = 4'b0001 << a;
        wdata_fmt = {4{src2_i[7:0]}};
      end
      2'b01: begin
        be_fmt    = a[1] ? 4'b1100 : 4'b0011;
        wdata_fmt = {2{src2_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load extraction. This relies on upstream holding result_i and mem_ctrl_i
  // stable for the whole access, so the live inputs are valid at ack time.
  always_comb begin
    case (a)
      2'd0:    ld_byte = dmem_rdata_i[7:0];
      2'd1:    ld_byte = dmem_rdata_i[15:8];
      2'd2:    ld_byte = dmem_rdata_i[23:16];
      default: ld_byte = dmem_rdata_i[31:24];
    endcase
    ld_half = a[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (size)
      2'b00:   load_ext = {{24{~uns & ld_byte[7]}}, ld_byte};
      2'b01:   load_ext = {{16{~uns & ld_half[15]}}, ld_half};
      default: load_ext = dmem_rdata_i;
    endcase
  end

`ifdef MISALIGN_EXC_EN
  logic          misal_q;
  logic [DW-1:0] bad_addr_q;

  assign misal = access & (((size == 2'b01) & a[0]) | (size[1] & (a != 2'b00)));

  // misal_q is set only on the IDLE->DONE skip edge, so it is high for
  // exactly the DONE cycle. bad_addr_q keeps its value until the next fault.
  always_ff @(negedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      misal_q    <= 1'b0;
      bad_addr_q <= '0;
    end else begin
      misal_q <= (state_q == IDLE) & misal;
      if ((state_q == IDLE) & misal) bad_addr_q <= result_i;
    end
  end

  assign misalign_o = misal_q;
  assign bad_addr_o = bad_addr_q;
`else
  assign misal = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    load_d  = load_q;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (misal) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
            req_d   = 1'b1;
            we_d    = mem_write;  // read+write together counts as a write
            addr_d  = {result_i[DW-1:2], 2'b00};
            be_d    = be_fmt;
            wdata_d = wdata_fmt;
          end
        end
      end
      BUSY: begin
        if (dmem_ack_i) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (!we_q) load_d = load_ext;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      wdata_q <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      load_q  <= load_d;
    end
  end

  // Low in DONE, so upstream advances on the edge that leaves DONE.
  assign stall_o = ((state_q == IDLE) & access) | (state_q == BUSY);

  // reg_write is withheld until the access reaches DONE.
  always_comb begin
    wb_ctrl_o = wb_ctrl_i;
    if (stall_o) wb_ctrl_o[0] = 1'b0;
`ifdef MISALIGN_EXC_EN
    if (misal_q) wb_ctrl_o[0] = 1'b0;
`endif
  end

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;
  assign alu_result_o = result_i;
  assign mem_data_o   = load_q;
  assign rd_o         = rd_i;
  assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage. Inputs are driven and outputs sampled
// just after the rising edge, which keeps them clear of the falling active
// edge. Expected bus fields and load data are queued when an access is
// driven, then popped when the DUT presents them.
module tb_mem_access_stage;

  localparam int BW = 69;  // {we, be[3:0], addr[31:0], wdata[31:0]}

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [4:0]  mem_ctrl_i;
  logic [1:0]  wb_ctrl_i;
  logic [31:0] result_i, src2_i;
  logic [4:0]  rd_i;
  logic        stall_o, dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic [1:0]  wb_ctrl_o;
  logic [31:0] alu_result_o, mem_data_o;
  logic [4:0]  rd_o;
  logic [1:0]  state_dbg_o;
`ifdef MISALIGN_EXC_EN
  logic        misalign_o;
  logic [31:0] bad_addr_o;
`endif

  logic [BW-1:0] exp_q[$];
  logic [31:0]   exp_data_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  mem_access_stage dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .mem_ctrl_i   (mem_ctrl_i),
    .wb_ctrl_i    (wb_ctrl_i),
    .result_i     (result_i),
    .src2_i       (src2_i),
    .rd_i         (rd_i),
    .stall_o      (stall_o),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_be_o    (dmem_be_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_ack_i   (dmem_ack_i),
    .dmem_rdata_i (dmem_rdata_i),
    .wb_ctrl_o    (wb_ctrl_o),
    .alu_result_o (alu_result_o),
    .mem_data_o   (mem_data_o),
    .rd_o         (rd_o),
`ifdef MISALIGN_EXC_EN
    .misalign_o   (misalign_o),
    .bad_addr_o   (bad_addr_o),
`endif
    .state_dbg_o  (state_dbg_o)
  );

  // Clock: rising edges at 5, 15, ...; active falling edges at 10, 20, ...
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // One memory access. Acks on the ack_wait-th BUSY cycle, puts junk on
  // rdata in every other cycle, and checks the stall length, the bus
  // fields, and the DONE-cycle outputs.
  task automatic mem_op(input string tag, input logic [4:0] ctrl,
                        input logic [31:0] addr, input logic [31:0] src2,
                        input logic [31:0] rdata, input int ack_wait,
                        input logic exp_we, input logic [3:0] exp_be,
                        input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_data);
    logic [BW-1:0] bus;
    logic [31:0]   d;
    logic [1:0]    wb;
    int stall_cnt;
    wb = ctrl[1] ? 2'b00 : 2'b01;
    exp_q.push_back({exp_we, exp_be, exp_addr, exp_wdata});
    exp_data_q.push_back(exp_data);
    @(posedge clk_i);
    mem_ctrl_i = ctrl; wb_ctrl_i = wb; result_i = addr; src2_i = src2;
    rd_i = 5'd7; dmem_rdata_i = $urandom;
    #1;
    chk({tag, " stall_idle"}, {31'd0, stall_o}, 32'd1);
    chk({tag, " wb_masked"}, {31'd0, wb_ctrl_o[0]}, 32'd0);
    stall_cnt = 1;
    for (int k = 1; k <= ack_wait; k++) begin
      step();
      if (stall_o) stall_cnt++;
      if (k == 1) begin
        bus = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        chk({tag, " req"}, {31'd0, dmem_req_o}, 32'd1);
        chk({tag, " we"}, {31'd0, dmem_we_o}, {31'd0, bus[68]});
        chk({tag, " be"}, {28'd0, dmem_be_o}, {28'd0, bus[67:64]});
        chk({tag, " addr"}, dmem_addr_o, bus[63:32]);
        if (bus[68]) chk({tag, " wdata"}, dmem_wdata_o, bus[31:0]);
      end
      if (k == ack_wait) begin
        dmem_ack_i = 1'b1; dmem_rdata_i = rdata;
      end else begin
        dmem_rdata_i = $urandom;
      end
    end
    step();
    dmem_ack_i = 1'b0; dmem_rdata_i = $urandom;
    #1;
    chk({tag, " stall_cycles"}, stall_cnt, 1 + ack_wait);
    chk({tag, " stall_done"}, {31'd0, stall_o}, 32'd0);
    chk({tag, " req_done"}, {31'd0, dmem_req_o}, 32'd0);
    chk({tag, " state_done"}, {30'd0, state_dbg_o}, 32'd2);
    chk({tag, " wb_done"}, {30'd0, wb_ctrl_o}, {30'd0, wb});
    if (exp_data_q.size() == 0) begin
      chk({tag, " scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      d = exp_data_q.pop_front();
      chk({tag, " mem_data"}, mem_data_o, d);
    end
  endtask

  initial begin
    rst_n_i = 1'b0; mem_ctrl_i = '0; wb_ctrl_i = '0; result_i = '0;
    src2_i = '0; rd_i = '0; dmem_ack_i = 1'b0; dmem_rdata_i = '0;
    step();
    chk("rst stall", {31'd0, stall_o}, 32'd0);
    chk("rst req", {31'd0, dmem_req_o}, 32'd0);
    chk("rst we", {31'd0, dmem_we_o}, 32'd0);
    chk("rst addr", dmem_addr_o, 32'd0);
    chk("rst be", {28'd0, dmem_be_o}, 32'd0);
    chk("rst wdata", dmem_wdata_o, 32'd0);
    chk("rst mem_data", mem_data_o, 32'd0);
    chk("rst state", {30'd0, state_dbg_o}, 32'd0);
`ifdef MISALIGN_EXC_EN
    chk("rst misalign", {31'd0, misalign_o}, 32'd0);
    chk("rst bad_addr", bad_addr_o, 32'd0);
`endif
    rst_n_i = 1'b1;

    // Non-memory instruction: no stall, combinational pass-through.
    step();
    mem_ctrl_i = 5'b00000; wb_ctrl_i = 2'b01; result_i = 32'h0000_0055; rd_i = 5'd3;
    #1;
    chk("add stall", {31'd0, stall_o}, 32'd0);
    chk("add wb", {30'd0, wb_ctrl_o}, 32'd1);
    chk("add alu", alu_result_o, 32'h0000_0055);
    chk("add rd", {27'd0, rd_o}, 32'd3);
    step();
    chk("add stays idle", {30'd0, state_dbg_o}, 32'd0);
    chk("add no req", {31'd0, dmem_req_o}, 32'd0);

    // Loads.
    mem_op("lw",   5'b01001, 32'h0000_0100, 32'h0, 32'h1234_5678, 3, 1'b0, 4'b1111, 32'h100, 32'h0, 32'h1234_5678);
    mem_op("lb",   5'b00001, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 1, 1'b0, 4'b1000, 32'h100, 32'h0, 32'hFFFF_FF80);
    mem_op("lbu",  5'b10001, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 2, 1'b0, 4'b1000, 32'h100, 32'h0, 32'h0000_0080);
    mem_op("lb0",  5'b00001, 32'h0000_0100, 32'h0, 32'h80FF_FFFF, 1, 1'b0, 4'b0001, 32'h100, 32'h0, 32'hFFFF_FFFF);
    mem_op("lh",   5'b00101, 32'h0000_0202, 32'h0, 32'h8001_7FFF, 1, 1'b0, 4'b1100, 32'h200, 32'h0, 32'hFFFF_8001);
    mem_op("lhu",  5'b10101, 32'h0000_0202, 32'h0, 32'h8001_7FFF, 2, 1'b0, 4'b1100, 32'h200, 32'h0, 32'h0000_8001);
    mem_op("lh0",  5'b00101, 32'h0000_0200, 32'h0, 32'h8001_7FFF, 1, 1'b0, 4'b0011, 32'h200, 32'h0, 32'h0000_7FFF);

    // Stores leave the last load value in place.
    mem_op("sb",   5'b00010, 32'h0000_0101, 32'h1234_56AB, 32'hFFFF_FFFF, 2, 1'b1, 4'b0010, 32'h100, 32'hABAB_ABAB, 32'h0000_7FFF);
    step();
    mem_ctrl_i = 5'b00000; wb_ctrl_i = 2'b01; result_i = 32'h0000_0009; rd_i = 5'd4;
    #1;
    chk("add after sb stall", {31'd0, stall_o}, 32'd0);
    chk("add after sb wb", {30'd0, wb_ctrl_o}, 32'd1);
    mem_op("sh",   5'b00110, 32'h0000_0202, 32'h0000_BEEF, 32'h0, 1, 1'b1, 4'b1100, 32'h200, 32'hBEEF_BEEF, 32'h0000_7FFF);
    mem_op("rwsw", 5'b01011, 32'h0000_0300, 32'hDEAD_BEEF, 32'h0, 1, 1'b1, 4'b1111, 32'h300, 32'hDEAD_BEEF, 32'h0000_7FFF);

    // Ack while idle is ignored.
    step();
    mem_ctrl_i = 5'b00000; dmem_ack_i = 1'b1; dmem_rdata_i = 32'h5555_AAAA;
    step();
    dmem_ack_i = 1'b0;
    #1;
    chk("idle ack state", {30'd0, state_dbg_o}, 32'd0);
    chk("idle ack req", {31'd0, dmem_req_o}, 32'd0);
    chk("idle ack data", mem_data_o, 32'h0000_7FFF);

    // Reset in the middle of BUSY.
    mem_ctrl_i = 5'b01001; wb_ctrl_i = 2'b01; result_i = 32'h0000_0100;
    step();
    chk("mid busy req", {31'd0, dmem_req_o}, 32'd1);
    chk("mid busy state", {30'd0, state_dbg_o}, 32'd1);
    rst_n_i = 1'b0;
    #1;
    chk("mid rst req", {31'd0, dmem_req_o}, 32'd0);
    chk("mid rst state", {30'd0, state_dbg_o}, 32'd0);
    chk("mid rst data", mem_data_o, 32'd0);
    chk("mid rst be", {28'd0, dmem_be_o}, 32'd0);
    chk("mid rst stall", {31'd0, stall_o}, 32'd1);
    mem_ctrl_i = 5'b00000;
    step();
    rst_n_i = 1'b1; dmem_ack_i = 1'b1; dmem_rdata_i = 32'h1111_2222;
    step();
    dmem_ack_i = 1'b0;
    #1;
    chk("late ack state", {30'd0, state_dbg_o}, 32'd0);
    chk("late ack req", {31'd0, dmem_req_o}, 32'd0);
    chk("late ack data", mem_data_o, 32'd0);

    // Misaligned word load.
`ifdef MISALIGN_EXC_EN
    step();
    mem_ctrl_i = 5'b01001; wb_ctrl_i = 2'b01; result_i = 32'h0000_0102;
    #1;
    chk("mis stall", {31'd0, stall_o}, 32'd1);
    step();
    chk("mis no req", {31'd0, dmem_req_o}, 32'd0);
    chk("mis state", {30'd0, state_dbg_o}, 32'd2);
    chk("mis pulse", {31'd0, misalign_o}, 32'd1);
    chk("mis bad_addr", bad_addr_o, 32'h0000_0102);
    chk("mis no wb", {31'd0, wb_ctrl_o[0]}, 32'd0);
    mem_ctrl_i = 5'b00000; result_i = 32'h0000_0040;
    step();
    chk("mis pulse end", {31'd0, misalign_o}, 32'd0);
    chk("mis bad_addr hold", bad_addr_o, 32'h0000_0102);
`else
    mem_op("lw_mis", 5'b01001, 32'h0000_0102, 32'h0, 32'hCAFE_F00D, 1, 1'b0, 4'b1111, 32'h100, 32'h0, 32'hCAFE_F00D);
`endif

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
